// File: rtl/fsm_step_sequencer_if.sv
// fsm_step_sequencer_if: run control and step handshake bundle.
// Signals: Start_req/Abort/Num_cycles/K1/K2 in; A/Busy/Done/Err/Cycle_cnt out.
interface fsm_step_sequencer_if;
  logic       Start_req;
  logic       Abort;
  logic [7:0] Num_cycles;
  logic       K1;
  logic       K2;
  logic       A;
  logic       Busy;
  logic       Done;
  logic       Err;
  logic [7:0] Cycle_cnt;

  modport master (
    output Start_req,
    output Abort,
    output Num_cycles,
    output K1,
    output K2,
    input  A,
    input  Busy,
    input  Done,
    input  Err,
    input  Cycle_cnt
  );

  modport slave (
    input  Start_req,
    input  Abort,
    input  Num_cycles,
    input  K1,
    input  K2,
    output A,
    output Busy,
    output Done,
    output Err,
    output Cycle_cnt
  );
endinterface

// File: rtl/fsm_step_sequencer.sv
// fsm_step_sequencer: drives A through Idle->Start->Stop->Clear cycles.
// Ports: Clock, Reset (sync, low), bus (slave). Option: SEQ_ACK_TIMEOUT_EN.
module fsm_step_sequencer #(
  parameter int unsigned HOLD    = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  fsm_step_sequencer_if.slave  bus
);

  if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
    $error("HOLD out of range 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_tmo
    $error("TIMEOUT out of range 1..255");
  end

  localparam logic [3:0] HoldLast = 4'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    P_RISE,
    P_FALL,
    P_ARM,
    P_REL,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic       a_q, a_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] num_q, num_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] cnt_inc;
  logic       in_run;

`ifdef SEQ_ACK_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);
  logic       err_q, err_d;
  logic [7:0] wait_q, wait_d;
  logic       wait_end;

  assign wait_end = (wait_q == TmoLast);
`endif

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  assign in_run = (state_q == P_RISE) ||
                  (state_q == P_FALL) ||
                  (state_q == P_ARM)  ||
                  (state_q == P_REL);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    num_d   = num_q;
    hold_d  = hold_q;
`ifdef SEQ_ACK_TIMEOUT_EN
    err_d   = err_q;
    wait_d  = wait_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start_req && !bus.Abort) begin
          num_d  = bus.Num_cycles;
          cnt_d  = 8'd0;
          hold_d = 4'd0;
`ifdef SEQ_ACK_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          if (bus.Num_cycles == 8'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            a_d     = 1'b0;
          end else begin
            state_d = P_RISE;
            busy_d  = 1'b1;
            a_d     = 1'b1;
          end
        end
      end
      P_RISE: begin
        if (hold_q == HoldLast) begin
          state_d = P_FALL;
          a_d     = 1'b0;
          hold_d  = 4'd0;
        end else begin
          hold_d  = hold_q + 4'd1;
        end
      end
      P_FALL: begin
        if (hold_q == HoldLast) begin
          state_d = P_ARM;
          a_d     = 1'b1;
          hold_d  = 4'd0;
`ifdef SEQ_ACK_TIMEOUT_EN
          wait_d  = 8'd0;
`endif
        end else begin
          hold_d  = hold_q + 4'd1;
        end
      end
      P_ARM: begin
        if (bus.K2) begin
          state_d = P_REL;
          a_d     = 1'b0;
`ifdef SEQ_ACK_TIMEOUT_EN
          wait_d  = 8'd0;
        end else if (wait_end) begin
          state_d = S_ERR;
          a_d     = 1'b0;
        end else begin
          wait_d  = wait_q + 8'd1;
`endif
        end
      end
      P_REL: begin
        if (bus.K1) begin
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            a_d     = 1'b0;
          end else begin
            state_d = P_RISE;
            a_d     = 1'b1;
            hold_d  = 4'd0;
          end
`ifdef SEQ_ACK_TIMEOUT_EN
        end else if (wait_end) begin
          state_d = S_ERR;
          a_d     = 1'b0;
        end else begin
          wait_d  = wait_q + 8'd1;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        a_d     = 1'b0;
`ifdef SEQ_ACK_TIMEOUT_EN
        err_d   = 1'b1;
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        a_d     = 1'b0;
      end
    endcase

    // Abort wins over any step decision taken above.
    if (in_run && bus.Abort) begin
      state_d = S_IDLE;
      a_d     = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
      num_q   <= 8'd0;
      hold_q  <= 4'd0;
`ifdef SEQ_ACK_TIMEOUT_EN
      err_q   <= 1'b0;
      wait_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      hold_q  <= hold_d;
`ifdef SEQ_ACK_TIMEOUT_EN
      err_q   <= err_d;
      wait_q  <= wait_d;
`endif
    end
  end

  assign bus.A         = a_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Cycle_cnt = cnt_q;
`ifdef SEQ_ACK_TIMEOUT_EN
  assign bus.Err       = err_q;
`else
  assign bus.Err       = 1'b0;
`endif

endmodule
